// File: rtl/byte_addr_memory.sv
// RV32 byte-addressed data memory: sync word RAM with byte enables, one-cycle loads,
// memory-mapped outport registers, one inport and a boot-time flash write port.
module byte_addr_memory #(
   parameter int          WIDTH        = 32,
   parameter int          DEPTH        = 2048,
   parameter int          NUM_OUTPORTS = 1,
   parameter logic [31:0] OUT_BASE     = 32'h0000_FFFC,
   parameter logic [31:0] IN_ADDR      = 32'h0000_FFE0,
   localparam int         AW           = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   input  logic                       req_wren,
   input  logic [WIDTH-1:0]           req_addr,
   input  logic [WIDTH-1:0]           req_wdata,
   input  logic [2:0]                 req_funct3,
   output logic                       rd_valid,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       err,
   input  logic                       flash_en,
   input  logic [AW-1:0]              flash_addr,
   input  logic [WIDTH-1:0]           flash_data,
   input  logic [WIDTH-1:0]           inport,
   output logic [NUM_OUTPORTS*32-1:0] outports
);

   localparam logic [WIDTH-1:0] RAM_BYTES = WIDTH'(4 * DEPTH);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [WIDTH-1:0]  outreg [NUM_OUTPORTS];

   logic [1:0]        off;
   logic [AW-1:0]     word;
   logic              f3_ok;
   logic              align_ok;
   logic              acc;
   logic              bad;
   logic              st;
   logic [NUM_OUTPORTS-1:0] out_hit;
   logic              io_out;
   logic              in_hit;
   logic              ram_sel;
   logic [3:0]        be;
   logic [WIDTH-1:0]  wd;
   logic [WIDTH-1:0]  out_rd;

   logic              valid_q;
   logic              err_q;
   logic              zero_q;
   logic              ram_sel_q;
   logic [1:0]        off_q;
   logic [2:0]        f3_q;
   logic [WIDTH-1:0]  ram_q;
   logic [WIDTH-1:0]  io_q;
   logic [WIDTH-1:0]  hold_q;
   logic [WIDTH-1:0]  src;
   logic [WIDTH-1:0]  lane;
   logic [WIDTH-1:0]  ext;

   assign off  = req_addr[1:0];
   assign word = req_addr[AW+1:2];

   always_comb begin
      f3_ok    = 1'b0;
      align_ok = 1'b1;
      case (req_funct3)
         3'b000: f3_ok = 1'b1;
         3'b001: begin f3_ok = 1'b1;       align_ok = ~off[0];      end
         3'b010: begin f3_ok = 1'b1;       align_ok = (off == 2'b00); end
         3'b100: f3_ok = ~req_wren;
         3'b101: begin f3_ok = ~req_wren;  align_ok = ~off[0];      end
         default: f3_ok = 1'b0;
      endcase
   end

   // Flash owns the RAM write port for the cycle, so any request is dropped.
   assign acc = req_valid & ~flash_en;
   assign bad = acc & ~(f3_ok & align_ok);
   assign st  = acc & req_wren & f3_ok & align_ok;

   for (genvar k = 0; k < NUM_OUTPORTS; k++) begin : g_out
      localparam logic [31:0] ADDR_K = OUT_BASE - 32'(4 * k);
      assign out_hit[k]            = (req_addr[WIDTH-1:2] == ADDR_K[31:2]);
      assign outports[32*k +: 32]  = outreg[k];
   end

   assign io_out  = |out_hit;
   assign in_hit  = (req_addr[WIDTH-1:2] == IN_ADDR[31:2]);
   assign ram_sel = (req_addr < RAM_BYTES) & ~io_out & ~in_hit;

   always_comb begin
      case (req_funct3[1:0])
         2'b00:   begin be = 4'b0001 << off; wd = {4{req_wdata[7:0]}};  end
         2'b01:   begin be = 4'b0011 << off; wd = {2{req_wdata[15:0]}}; end
         default: begin be = 4'b1111;        wd = req_wdata;            end
      endcase
   end

   always_comb begin
      out_rd = '0;
      for (int k = 0; k < NUM_OUTPORTS; k++)
         if (out_hit[k]) out_rd = outreg[k];
   end

   always_ff @(posedge clk) begin
      if (flash_en)
         mem[flash_addr] <= flash_data;
      else if (st && ram_sel)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[word][8*i +: 8] <= wd[8*i +: 8];
      ram_q <= mem[word];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         zero_q    <= 1'b0;
         ram_sel_q <= 1'b0;
         off_q     <= '0;
         f3_q      <= '0;
         io_q      <= '0;
         hold_q    <= '0;
         for (int k = 0; k < NUM_OUTPORTS; k++) outreg[k] <= '0;
      end else begin
         valid_q   <= acc & ~req_wren;
         err_q     <= bad;
         zero_q    <= bad | ~(ram_sel | io_out | in_hit);
         ram_sel_q <= ram_sel;
         off_q     <= off;
         f3_q      <= req_funct3;
         io_q      <= io_out ? out_rd : inport;
         if (valid_q) hold_q <= ext;
         for (int k = 0; k < NUM_OUTPORTS; k++)
            for (int i = 0; i < 4; i++)
               if (st && out_hit[k] && be[i]) outreg[k][8*i +: 8] <= wd[8*i +: 8];
      end
   end

   always_comb begin
      src  = zero_q ? '0 : (ram_sel_q ? ram_q : io_q);
      lane = src >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
         3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
         3'b100:  ext = {24'b0, lane[7:0]};
         3'b101:  ext = {16'b0, lane[15:0]};
         default: ext = lane;
      endcase
   end

   // Reset in the response cycle suppresses the pending load result.
   assign rd_valid = valid_q & ~rst;
   assign err      = err_q & ~rst;
   assign rd_data  = rd_valid ? ext : hold_q;

endmodule

// File: tb/tb_byte_addr_memory.sv
// Randomized bench for byte_addr_memory against a byte-array reference model.
module tb_byte_addr_memory;

   localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_wren = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [2:0]  req_funct3 = '0;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        err;
   logic        flash_en = 1'b0;
   logic [10:0] flash_addr = '0;
   logic [31:0] flash_data = '0;
   logic [31:0] inport = '0;
   logic [31:0] outports;

   always #5 clk = ~clk;

   byte_addr_memory dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_wren(req_wren), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_funct3(req_funct3),
      .rd_valid(rd_valid), .rd_data(rd_data), .err(err),
      .flash_en(flash_en), .flash_addr(flash_addr), .flash_data(flash_data),
      .inport(inport), .outports(outports)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic        exp_valid = 1'b0;
   logic        exp_err   = 1'b0;
   logic [31:0] exp_hold  = '0;
   logic [7:0]  mb [8192];
   logic [31:0] mout = '0;
   logic [31:0] cur_in = '0;
   logic [2:0]  legal_f3 [5] = '{F_B, F_H, F_W, F_BU, F_HU};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] extract(input logic [31:0] w32, input int off,
                                           input int size, input bit sgn);
      logic [31:0] v;
      v = w32 >> (8 * off);
      if (size == 1) begin
         v &= 32'hFF;
         if (sgn && v[7]) v |= 32'hFFFF_FF00;
      end else if (size == 2) begin
         v &= 32'hFFFF;
         if (sgn && v[15]) v |= 32'hFFFF_0000;
      end
      return v;
   endfunction

   task automatic model_req(input logic v, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [2:0] f3, input logic fe,
                            input logic [10:0] fa, input logic [31:0] fd, input logic [31:0] inv);
      int          size, off, base;
      bit          legal, is_out, is_in;
      logic [31:0] w32;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (fe) begin
         for (int i = 0; i < 4; i++) mb[int'(fa) * 4 + i] = fd[8*i +: 8];
         return;
      end
      if (!v) return;
      size   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off    = int'(a[1:0]);
      legal  = (f3 inside {F_B, F_H, F_W, F_BU, F_HU}) && !(w && f3[2]) && (off % size == 0);
      is_out = (a >> 2) == (32'h0000_FFFC >> 2);
      is_in  = (a >> 2) == (32'h0000_FFE0 >> 2);
      if (!legal) begin
         exp_err = 1'b1;
         if (!w) begin exp_valid = 1'b1; exp_hold = '0; end
         return;
      end
      if (w) begin
         if (is_out)
            for (int i = 0; i < size; i++) mout[8*(off+i) +: 8] = wd[8*i +: 8];
         else if (!is_in && a < 32'd8192)
            for (int i = 0; i < size; i++) mb[int'(a) + i] = wd[8*i +: 8];
      end else begin
         exp_valid = 1'b1;
         base = int'(a) & ~3;
         if (is_out)                w32 = mout;
         else if (is_in)            w32 = inv;
         else if (a < 32'd8192)     w32 = {mb[base+3], mb[base+2], mb[base+1], mb[base]};
         else begin exp_hold = '0; return; end
         exp_hold = extract(w32, off, size, f3[2] == 1'b0);
      end
   endtask

   // Called at posedge+1: drive, check previous response at negedge, advance model.
   task automatic cycle(input logic v, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input logic fe, input logic [10:0] fa,
                        input logic [31:0] fd, input logic [31:0] inv);
      req_valid = v; req_wren = w; req_addr = a; req_wdata = wd; req_funct3 = f3;
      flash_en = fe; flash_addr = fa; flash_data = fd; inport = inv;
      @(negedge clk);
      chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
      chk("err", 32'(err), 32'(exp_err));
      chk("rd_data", rd_data, exp_hold);
      chk("outport0", outports, mout);
      model_req(v, w, a, wd, f3, fe, fa, fd, inv);
      @(posedge clk); #1;
   endtask

   task automatic ld(input logic [31:0] a, input logic [2:0] f3);
      cycle(1'b1, 1'b0, a, '0, f3, 1'b0, '0, '0, cur_in);
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
      cycle(1'b1, 1'b1, a, wd, f3, 1'b0, '0, '0, cur_in);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, cur_in);
   endtask

   task automatic reset_pulse();
      rst = 1'b1; req_valid = 1'b0; flash_en = 1'b0;
      @(negedge clk);
      chk("rst_cancel_valid", 32'(rd_valid), 32'd0);
      chk("rst_cancel_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_valid = 1'b0; exp_err = 1'b0; exp_hold = '0; mout = '0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle();

      for (int i = 0; i < 64; i++)
         cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 11'(i), $urandom, cur_in);
      cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 11'd2047, $urandom, cur_in);

      st(32'h10, 32'h8000_00F1, F_W);
      ld(32'h10, F_B);   chk("t1_lb", rd_data, 32'hFFFF_FFF1);
      ld(32'h13, F_BU);  chk("t1_lbu", rd_data, 32'h0000_0080);

      st(32'h20, 32'h1122_3344, F_W);
      st(32'h21, 32'h0000_00AB, F_B);
      ld(32'h20, F_W);   chk("t2_merge", rd_data, 32'h1122_AB44);

      st(32'h32, 32'h0000_BEEF, F_H);
      ld(32'h32, F_H);   chk("t3_lh", rd_data, 32'hFFFF_BEEF);
      ld(32'h32, F_HU);  chk("t3_lhu", rd_data, 32'h0000_BEEF);
      ld(32'h31, F_H);   chk("t3_mis_err", 32'(err), 32'd1); chk("t3_mis_data", rd_data, 32'd0);

      st(32'hFFFC, 32'h0000_005A, F_W); chk("t4_outport", outports, 32'h0000_005A);
      st(32'h2, 32'h1234_5678, F_W);    chk("t4_mis_err", 32'(err), 32'd1);
      ld(32'h0, F_W);

      cur_in = 32'h0000_CAFE;
      ld(32'hFFE0, F_W); chk("t5_inport", rd_data, 32'h0000_CAFE);
      cycle(1'b1, 1'b0, 32'h14, '0, F_W, 1'b1, 11'd5, 32'h77, cur_in);
      chk("t5_flash_drop", 32'(rd_valid), 32'd0);
      ld(32'h14, F_W);   chk("t5_flash_rd", rd_data, 32'h0000_0077);
      ld(32'h4000, F_W); chk("unmapped_err", 32'(err), 32'd0);

      ld(32'h0, F_W);
      ld(32'h4, F_W);
      reset_pulse();
      chk("t6_rd_data", rd_data, 32'd0);
      chk("t6_outport", outports, 32'd0);
      idle();

      for (int n = 0; n < 800; n++) begin
         logic [31:0] a, wd, fd;
         logic [2:0]  f3;
         logic        v, w, fe;
         logic [10:0] fa;
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: a = 32'($urandom_range(0, 255));
            5:             a = 32'h1FFC + 32'($urandom_range(0, 3));
            6:             a = 32'hFFFC + 32'($urandom_range(0, 3));
            7:             a = 32'hFFE0 + 32'($urandom_range(0, 3));
            8:             a = 32'h4000 + 32'($urandom_range(0, 255));
            default:       a = 32'h8000_0000 | $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
         else                           f3 = legal_f3[$urandom_range(0, 4)];
         v  = ($urandom_range(0, 9) != 0);
         w  = 1'($urandom_range(0, 1));
         fe = ($urandom_range(0, 11) == 0);
         fa = 11'($urandom_range(0, 63));
         wd = $urandom;
         fd = $urandom;
         cur_in = $urandom;
         cycle(v, w, a, wd, f3, fe, fa, fd, cur_in);
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
